// File: rtl/umi_endpoint.sv
// umi_endpoint: UMI device-side request endpoint executing one request at a time against a local memory.
// Ports: udev_req_* accepts requests (valid/ready), udev_resp_* returns responses (valid/ready),
// loc_* drives a single-port local memory with one-cycle read latency, cmd_dropped pulses on discarded requests.
module umi_endpoint #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready,
    output logic [AW-1:0] loc_addr,
    output logic          loc_read,
    output logic          loc_write,
    output logic [DW-1:0] loc_wrdata,
    input  logic [DW-1:0] loc_rddata,
    output logic          cmd_dropped
);
    localparam logic [3:0] REQ_READ = 4'd1, REQ_WRITE = 4'd3, REQ_POSTED = 4'd5, REQ_ATOMIC = 4'd9;
    localparam logic [3:0] RESP_READ = 4'd2, RESP_WRITE = 4'd4;
    typedef enum logic [2:0] {IDLE, EXEC, WAIT, ATOMW, RESP} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cmd;
    logic [AW-1:0] r_dst, r_src;
    logic [DW-1:0] r_data, r_old, w_amo;
    logic          r_drop;
    logic [3:0]    w_in_opc, w_opc;
    logic          w_ok, w_acc, w_rmw, w_resp;
    assign w_in_opc = udev_req_cmd[3:0];
    assign w_ok = (udev_req_cmd[7:0] != 8'h00) &&
                  (w_in_opc == REQ_READ || w_in_opc == REQ_WRITE || w_in_opc == REQ_POSTED ||
                   (w_in_opc == REQ_ATOMIC && udev_req_cmd[15:8] <= 8'd8));
    assign w_acc = udev_req_valid && udev_req_ready;
    assign w_opc = r_cmd[3:0];
    assign w_rmw = (w_opc == REQ_READ) || (w_opc == REQ_ATOMIC);
    assign w_resp = (r_state == RESP);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_dst   <= '0;
            r_src   <= '0;
            r_data  <= '0;
            r_old   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drop  <= w_acc && !w_ok;
            if (w_acc) begin
                r_cmd  <= udev_req_cmd;
                r_dst  <= udev_req_dstaddr;
                r_src  <= udev_req_srcaddr;
                r_data <= udev_req_data;
            end
            if (r_state == WAIT) r_old <= loc_rddata;
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_acc && w_ok) ? EXEC : IDLE;
            EXEC:    w_next = w_rmw ? WAIT : (w_opc == REQ_WRITE ? RESP : IDLE);
            WAIT:    w_next = (w_opc == REQ_ATOMIC) ? ATOMW : RESP;
            ATOMW:   w_next = RESP;
            RESP:    w_next = udev_resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        w_amo = '0;
        case (r_cmd[15:8])
            8'd0:    w_amo = r_old + r_data;
            8'd1:    w_amo = r_old & r_data;
            8'd2:    w_amo = r_old | r_data;
            8'd3:    w_amo = r_old ^ r_data;
            8'd4:    w_amo = ($signed(r_old) > $signed(r_data)) ? r_old : r_data;
            8'd5:    w_amo = ($signed(r_old) < $signed(r_data)) ? r_old : r_data;
            8'd6:    w_amo = (r_old > r_data) ? r_old : r_data;
            8'd7:    w_amo = (r_old < r_data) ? r_old : r_data;
            8'd8:    w_amo = r_data;
            default: w_amo = '0;
        endcase
    end
    // ready is masked by reset so it reads 0 throughout reset, not just after the first edge
    assign udev_req_ready    = (r_state == IDLE) && !reset;
    assign loc_read          = (r_state == EXEC) && w_rmw;
    assign loc_write         = ((r_state == EXEC) && !w_rmw) || (r_state == ATOMW);
    assign loc_addr          = (r_state == EXEC || r_state == ATOMW) ? r_dst : '0;
    assign loc_wrdata        = loc_write ? ((r_state == ATOMW) ? w_amo : r_data) : '0;
    assign udev_resp_valid   = w_resp;
    assign udev_resp_cmd     = w_resp ? {r_cmd[CW-1:4], (w_opc == REQ_WRITE) ? RESP_WRITE : RESP_READ} : '0;
    assign udev_resp_dstaddr = w_resp ? r_src : '0;
    assign udev_resp_srcaddr = w_resp ? r_dst : '0;
    assign udev_resp_data    = (w_resp && w_opc != REQ_WRITE) ? r_old : '0;
    assign cmd_dropped       = r_drop;
endmodule

// File: tb/tb_umi_endpoint.sv
// tb_umi_endpoint: directed bench with a transaction-level model of umi_endpoint and a per-cycle compare process.
module tb_umi_endpoint;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        udev_req_valid = 1'b0;
    logic [31:0] udev_req_cmd = '0;
    logic [63:0] udev_req_dstaddr = '0;
    logic [63:0] udev_req_srcaddr = '0;
    logic [63:0] udev_req_data = '0;
    logic        udev_req_ready;
    logic        udev_resp_valid;
    logic [31:0] udev_resp_cmd;
    logic [63:0] udev_resp_dstaddr;
    logic [63:0] udev_resp_srcaddr;
    logic [63:0] udev_resp_data;
    logic        udev_resp_ready = 1'b1;
    logic [63:0] loc_addr;
    logic        loc_read;
    logic        loc_write;
    logic [63:0] loc_wrdata;
    logic [63:0] loc_rddata = '0;
    logic        cmd_dropped;

    umi_endpoint #(.CW(32), .AW(64), .DW(64)) dut (
        .clk(clk), .reset(reset),
        .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
        .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
        .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
        .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
        .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
        .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
        .loc_addr(loc_addr), .loc_read(loc_read), .loc_write(loc_write),
        .loc_wrdata(loc_wrdata), .loc_rddata(loc_rddata), .cmd_dropped(cmd_dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // local memory seen by the DUT: one-cycle read latency
    logic [63:0] dev_mem [0:255] = '{default: '0};
    always @(posedge clk) begin
        if (loc_write) dev_mem[loc_addr[10:3]] <= loc_wrdata;
        if (loc_read) loc_rddata <= dev_mem[loc_addr[10:3]];
    end

    // model state
    logic [63:0] mdl_mem [0:255] = '{default: '0};
    int n_cmp = 0, n_fail = 0;
    int rd_cyc = -1, wr_cyc = -1, drop_cyc = -1, free_cyc = 0, pend_start = 0;
    bit pend = 1'b0;
    logic [63:0] e_addr = '0, e_wdata = '0, e_rdst = '0, e_rsrc = '0, e_rdata = '0;
    logic [31:0] e_rcmd = '0;
    int n_resp = 0, n_drop = 0, hs_cyc = 0, last_acc = 0;
    logic [63:0] last_data = '0, last_dst = '0;
    logic [31:0] last_cmd = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] amo(input logic [7:0] s, input logic [63:0] a, input logic [63:0] b);
        longint sa = a, sb = b;
        if (s == 0) return a + b;
        if (s == 1) return a & b;
        if (s == 2) return a | b;
        if (s == 3) return a ^ b;
        if (s == 4) return (sa >= sb) ? a : b;
        if (s == 5) return (sa <= sb) ? a : b;
        if (s == 6) return (a >= b) ? a : b;
        if (s == 7) return (a <= b) ? a : b;
        return b;
    endfunction

    // issue one request; the model schedules every strobe and the response relative to the accept cycle
    task automatic send(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s,
                        input logic [63:0] w, input bit hold);
        int n, c0, i;
        logic [3:0] op;
        logic [7:0] sb;
        @(negedge clk);
        udev_req_valid = 1'b1;
        udev_req_cmd = c;
        udev_req_dstaddr = d;
        udev_req_srcaddr = s;
        udev_req_data = w;
        n = 0;
        while (!udev_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!udev_req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 for cmd %h", c);
            udev_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) udev_req_valid = 1'b0;
        c0 = cyc - 1;
        last_acc = c0;
        i = int'(d[10:3]);
        op = c[3:0];
        sb = c[15:8];
        e_addr = d;
        e_rdst = s;
        e_rsrc = d;
        e_rcmd = {c[31:4], (op == 4'd3) ? 4'h4 : 4'h2};
        if (c[7:0] == 8'h00 || !(op == 1 || op == 3 || op == 5 || (op == 9 && sb <= 8))) begin
            drop_cyc = c0 + 1;
            free_cyc = c0 + 1;
        end else if (op == 1) begin
            rd_cyc = c0 + 1;
            e_rdata = mdl_mem[i];
            pend = 1'b1;
            pend_start = c0 + 3;
        end else if (op == 9) begin
            rd_cyc = c0 + 1;
            wr_cyc = c0 + 3;
            e_rdata = mdl_mem[i];
            e_wdata = amo(sb, mdl_mem[i], w);
            mdl_mem[i] = e_wdata;
            pend = 1'b1;
            pend_start = c0 + 4;
        end else begin
            wr_cyc = c0 + 1;
            e_wdata = w;
            mdl_mem[i] = w;
            if (op == 3) begin
                e_rdata = '0;
                pend = 1'b1;
                pend_start = c0 + 2;
            end else free_cyc = c0 + 2;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (pend && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pend) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_timeout: got no response handshake expected one");
            pend = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    // per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        chk("req_ready", udev_req_ready, !reset && !pend && cyc >= free_cyc);
        chk("loc_read", loc_read, cyc == rd_cyc);
        chk("loc_write", loc_write, cyc == wr_cyc);
        if (loc_read || loc_write) chk("loc_addr", loc_addr, e_addr);
        if (loc_write) chk("loc_wrdata", loc_wrdata, e_wdata);
        chk("cmd_dropped", cmd_dropped, cyc == drop_cyc);
        if (cmd_dropped) n_drop++;
        chk("resp_valid", udev_resp_valid, pend && cyc >= pend_start);
        if (udev_resp_valid && pend && cyc >= pend_start) begin
            chk("resp_cmd", udev_resp_cmd, e_rcmd);
            chk("resp_dstaddr", udev_resp_dstaddr, e_rdst);
            chk("resp_srcaddr", udev_resp_srcaddr, e_rsrc);
            chk("resp_data", udev_resp_data, e_rdata);
            if (udev_resp_ready) begin
                pend = 1'b0;
                free_cyc = cyc + 1;
                hs_cyc = cyc;
                n_resp++;
                last_data = udev_resp_data;
                last_cmd = udev_resp_cmd;
                last_dst = udev_resp_dstaddr;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0, d0;
        logic [63:0] saved;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", udev_req_ready, 0);
        chk("rst_resp_valid", udev_resp_valid, 0);
        chk("rst_loc_strobes", {loc_read, loc_write, cmd_dropped}, 0);
        chk("rst_resp_fields", udev_resp_data | udev_resp_dstaddr | udev_resp_srcaddr | 64'(udev_resp_cmd), 0);
        chk("rst_loc_fields", loc_addr | loc_wrdata, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_release", udev_req_ready, 1);

        // write then read
        send(32'h1234_5603, 64'h100, 64'hCAFE_0000, 64'hDEADBEEF_00000001, 0);
        drain();
        chk("write_resp_cmd", last_cmd, 32'h1234_5604);
        chk("write_resp_data", last_data, 0);
        send(32'h1234_5601, 64'h100, 64'hCAFE_0000, 64'h0, 0);
        drain();
        chk("read_resp_cmd", last_cmd, 32'h1234_5602);
        chk("read_resp_data", last_data, 64'hDEADBEEF_00000001);
        chk("read_resp_dst", last_dst, 64'hCAFE_0000);

        // atomics on 0x108
        send(32'h0000_0003, 64'h108, 64'h40, 64'hFFFFFFFF_FFFFFFFF, 0);
        drain();
        send(32'h0000_0009, 64'h108, 64'h40, 64'h2, 0);
        drain();
        chk("add_old", last_data, 64'hFFFFFFFF_FFFFFFFF);
        chk("add_mem", dev_mem[8'h21], 64'h1);
        send(32'h0000_0409, 64'h108, 64'h40, 64'hFFFFFFFF_FFFFFFFF, 0);
        drain();
        chk("max_old", last_data, 64'h1);
        chk("max_mem", dev_mem[8'h21], 64'h1);
        send(32'h0000_0609, 64'h108, 64'h40, 64'hFFFFFFFF_FFFFFFFF, 0);
        drain();
        chk("maxu_old", last_data, 64'h1);
        chk("maxu_mem", dev_mem[8'h21], 64'hFFFFFFFF_FFFFFFFF);
        send(32'h0000_0809, 64'h108, 64'h40, 64'h77, 0);
        drain();
        chk("swap_mem", dev_mem[8'h21], 64'h77);

        // back-to-back posted writes
        r0 = n_resp;
        send(32'h0000_0005, 64'h110, 64'h0, 64'h1111, 1);
        a0 = last_acc;
        send(32'h0000_0005, 64'h118, 64'h0, 64'h2222, 1);
        chk("posted_gap1", 64'(last_acc - a0), 2);
        a0 = last_acc;
        send(32'h0000_0005, 64'h120, 64'h0, 64'h3333, 0);
        chk("posted_gap2", 64'(last_acc - a0), 2);
        drain();
        chk("posted_no_resp", 64'(n_resp - r0), 0);
        chk("posted_mem", dev_mem[8'h23], 64'h2222);

        // read with response back-pressure
        udev_resp_ready = 1'b0;
        send(32'h0000_0001, 64'h118, 64'h50, 64'h0, 0);
        repeat (7) @(posedge clk);
        #1;
        udev_resp_ready = 1'b1;
        send(32'h0000_0001, 64'h110, 64'h50, 64'h0, 0);
        chk("accept_after_resp", 64'(last_acc - hs_cyc), 1);
        chk("stall_data", last_data, 64'h2222);
        drain();

        // unsupported requests
        d0 = n_drop;
        r0 = n_resp;
        send(32'h0000_0000, 64'h100, 64'h0, 64'h9, 0);
        send(32'h0000_0002, 64'h100, 64'h0, 64'h9, 0);
        send(32'h0000_0F09, 64'h100, 64'h0, 64'h9, 0);
        drain();
        chk("drop_count", 64'(n_drop - d0), 3);
        chk("drop_no_resp", 64'(n_resp - r0), 0);

        // reset during an atomic
        send(32'h0000_0003, 64'h130, 64'h0, 64'h55, 0);
        drain();
        saved = mdl_mem[8'h26];
        send(32'h0000_0009, 64'h130, 64'h0, 64'h5, 0);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        pend = 1'b0;
        rd_cyc = -1;
        wr_cyc = -1;
        free_cyc = 0;
        mdl_mem[8'h26] = saved;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_mid_reset", udev_req_ready, 1);
        chk("reset_no_write", dev_mem[8'h26], 64'h55);
        drain();

        for (int i = 0; i < 256; i++) chk("mem", dev_mem[i], mdl_mem[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
